// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port synchronous memory.
// Port A has fixed priority, and port B gets a forced grant once its wait reaches STARVE_MAX.
// Defining MEM_ARB_STATS_EN adds the saturating grant and conflict counters.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]           grant_cnt_a,
  output logic [15:0]           grant_cnt_b,
  output logic [15:0]           conflict_cnt,
`endif
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam int WAIT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  logic [WAIT_W-1:0]     wait_cnt;
  owner_e                rd_owner;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  both_req;
  logic                  starved;

  assign both_req = req_a & req_b;
  assign starved  = (wait_cnt == STARVE_LIM);

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    // NOTE: assign every always_comb output a default first so that no path infers a latch.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (req_a && !(req_b && starved)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // Idle cycles keep the last granted address/data on the bus, and the write strobe is held low.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = hold_addr;
    mem_data = hold_data;
    if (gnt_a) begin
      mem_we   = we_a;
      mem_addr = addr_a;
      mem_data = wdata_a;
    end else if (gnt_b) begin
      mem_we   = we_b;
      mem_addr = addr_b;
      mem_data = wdata_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      rd_owner  <= OWN_NONE;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      if (gnt_b) begin
        wait_cnt <= '0;
      end else if (both_req && gnt_a && !starved) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (gnt_a || gnt_b) begin
        hold_addr <= mem_addr;
        hold_data <= mem_data;
      end
      if (gnt_a && !we_a) begin
        rd_owner <= OWN_A;
      end else if (gnt_b && !we_b) begin
        rd_owner <= OWN_B;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  assign rvalid_a = (rd_owner == OWN_A);
  assign rvalid_b = (rd_owner == OWN_B);
  assign rdata_a  = rvalid_a ? mem_out : '0;
  assign rdata_b  = rvalid_b ? mem_out : '0;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_a  <= '0;
      grant_cnt_b  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_a && grant_cnt_a != 16'hFFFF) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (gnt_b && grant_cnt_b != 16'hFFFF) grant_cnt_b <= grant_cnt_b + 16'd1;
      if (both_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
  a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(rvalid_a && rvalid_b));
  a_wait_bound: assert property (@(posedge clk) disable iff (!rst_n) wait_cnt <= STARVE_LIM);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural model checked on every cycle, plus directed vectors
// whose literal expectations pin that model. A memory model sits behind the arbiter.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int STARVE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, mem_we;
  logic [DW-1:0] rdata_a, rdata_b, mem_data, mem_out;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b, conflict_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef MEM_ARB_STATS_EN
    .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .conflict_cnt(conflict_cnt),
`endif
    .mem_out(mem_out)
  );

  // Single-port synchronous memory with a registered read port.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_out <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the arbitration rules applied to the current inputs, with a shadow memory image.
  logic [DW-1:0] model_mem [64];
  int            lost;
  int            pend;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic          ea, eb, ewe;
  logic [AW-1:0] eaddr;
  logic [DW-1:0] edata;
  int            cnt_ga, cnt_gb, cnt_conf;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt_a", gnt_a, 0);
      check("rst_gnt_b", gnt_b, 0);
      check("rst_rvalid_a", rvalid_a, 0);
      check("rst_rvalid_b", rvalid_b, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_rdata_b", rdata_b, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_wait_cnt", dut.wait_cnt, 0);
      lost = 0; pend = 0; pend_data = '0; last_addr = '0; last_data = '0;
      cnt_ga = 0; cnt_gb = 0; cnt_conf = 0;
    end else begin
      ea = req_a && !(req_b && lost == STARVE);
      eb = req_b && !ea;
      ewe = (ea && we_a) || (eb && we_b);
      eaddr = ea ? addr_a : (eb ? addr_b : last_addr);
      edata = ea ? wdata_a : (eb ? wdata_b : last_data);
      check("gnt_a", gnt_a, ea);
      check("gnt_b", gnt_b, eb);
      check("mem_we", mem_we, ewe);
      check("mem_addr", mem_addr, eaddr);
      check("mem_data", mem_data, edata);
      check("rvalid_a", rvalid_a, pend == 1);
      check("rvalid_b", rvalid_b, pend == 2);
      check("rdata_a", rdata_a, (pend == 1) ? pend_data : '0);
      check("rdata_b", rdata_b, (pend == 2) ? pend_data : '0);
      check("wait_cnt", dut.wait_cnt, lost);
`ifdef MEM_ARB_STATS_EN
      check("grant_cnt_a", grant_cnt_a, cnt_ga);
      check("grant_cnt_b", grant_cnt_b, cnt_gb);
      check("conflict_cnt", conflict_cnt, cnt_conf);
`endif
      if (req_a && req_b && ea) lost++;
      if (eb) lost = 0;
      if (ea && cnt_ga < 65535) cnt_ga++;
      if (eb && cnt_gb < 65535) cnt_gb++;
      if (req_a && req_b && cnt_conf < 65535) cnt_conf++;
      if (ea || eb) begin
        last_addr = eaddr;
        last_data = edata;
      end
      pend = 0;
      if (ea && !we_a) begin pend = 1; pend_data = model_mem[addr_a]; end
      if (eb && !we_b) begin pend = 2; pend_data = model_mem[addr_b]; end
      if (ewe) model_mem[eaddr] = edata;
    end
  end

  // Apply one cycle of inputs just after a rising edge and return once this cycle's outputs have settled.
  task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    @(posedge clk); #1;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [7:0] seq;
    int ga, gb;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'h0100 + 16'(i);
      model_mem[i] = 16'h0100 + 16'(i);
    end
    mem[5] = 16'h1234;
    model_mem[5] = 16'h1234;

    // A request held through reset must not be granted.
    req_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("gnt_in_reset", gnt_a, 0);
    req_a = 1'b0;
    rst_n = 1'b1;

    // Port A read of address 5.
    drive(1, 0, 6'd5, '0, 0, 0, '0, '0);
    check("a_rd_gnt", gnt_a, 1);
    idle();
    check("a_rd_rvalid", rvalid_a, 1);
    check("a_rd_rdata", rdata_a, 16'h1234);
    check("a_rd_rvalid_b", rvalid_b, 0);

    // Continuous contention for 8 cycles: the expected grant pattern is A,A,A,B,A,A,A,B.
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 6'd5, '0, 1, 0, 6'd9, '0);
      seq[i] = gnt_b;
    end
    check("contend_seq", seq, 8'b1000_1000);
    idle();

    // B writes 0x00AB to address 9, then A reads address 9.
    drive(0, 0, '0, '0, 1, 1, 6'd9, 16'h00AB);
    check("b_wr_gnt", gnt_b, 1);
    drive(1, 0, 6'd9, '0, 0, 0, '0, '0);
    check("a_rd9_gnt", gnt_a, 1);
    idle();
    check("wr_rd_rvalid", rvalid_a, 1);
    check("wr_rd_rdata", rdata_a, 16'h00AB);

    // A write followed by four idle cycles.
    drive(1, 1, 6'd12, 16'h5A5A, 0, 0, '0, '0);
    check("hold_wr_we", mem_we, 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("hold_we", mem_we, 0);
      check("hold_addr", mem_addr, 12);
      check("hold_rvalid_a", rvalid_a, 0);
      check("hold_rvalid_b", rvalid_b, 0);
    end

    // Mixed traffic. Each side keeps its command until that command is granted.
    ga = 0; gb = 0;
    for (int i = 0; i < 24; i++) begin
      drive((i % 4) != 3, ga[0], 6'((ga * 3) % 64), 16'(16'h1000 + ga),
            (i % 3) != 0, (gb % 3) == 0, 6'((gb * 5 + 1) % 64), 16'(16'h2000 + gb));
      if (gnt_a) ga++;
      if (gnt_b) gb++;
    end
    idle();

    // Reset asserted in the same cycle as a granted B read.
    drive(1, 0, 6'd5, '0, 1, 0, 6'd9, '0);
    drive(1, 0, 6'd5, '0, 1, 0, 6'd9, '0);
    drive(0, 0, '0, '0, 1, 0, 6'd9, '0);
    check("rst_b_gnt", gnt_b, 1);
    rst_n = 1'b0;
    #1;
    check("rst_b_gnt_drop", gnt_b, 0);
    check("rst_b_addr", mem_addr, 0);
    req_b = 1'b0;
    @(negedge clk); #1;
    check("rst_b_rvalid", rvalid_b, 0);
    check("rst_b_wait", dut.wait_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 0, 6'd5, '0, 1, 0, 6'd9, '0);
    check("post_rst_gnt_a", gnt_a, 1);
    check("post_rst_gnt_b", gnt_b, 0);
    idle();

`ifdef MEM_ARB_STATS_EN
    // Run contention long enough to saturate the conflict counter, then confirm that it stays saturated.
    for (int i = 0; i < 65535; i++) drive(1, 0, 6'd5, '0, 1, 0, 6'd9, '0);
    idle();
    check("conf_sat", conflict_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) drive(1, 0, 6'd5, '0, 1, 0, 6'd9, '0);
    idle();
    check("conf_stay", conflict_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
